// File: rtl/draw_source_sequencer.sv
// draw_source_sequencer: hands the shared frame-buffer write bus to each enabled
// draw source in ascending ID order once per frame. Between two grants there is a
// one-cycle guard gap. A watchdog forces the bus onward if a source overstays its
// grant. A frame pulse that arrives mid-sequence aborts the sequence and restarts it.
module draw_source_sequencer #(
  parameter int NUM_SOURCES      = 3,
  parameter int SOURCE_SEL_ADDRW = 2,
  parameter int TIMEOUT_CYCLES   = 400000,
  parameter int OVR_CNT_W        = 8
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        frame,
  input  logic [NUM_SOURCES-1:0]      src_enable,
  input  logic [NUM_SOURCES-1:0]      src_done,
  input  logic                        clear_status,
  output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
  output logic                        write_awaited,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        timeout_flag,
  output logic [OVR_CNT_W-1:0]        overrun_count
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP, DONE} state_t;

  state_t                      state_q, state_d;
  logic [SOURCE_SEL_ADDRW-1:0] sel_q, sel_d;
  logic                        awaited_q, awaited_d;
  logic                        busy_q, busy_d;
  logic                        frame_done_q, frame_done_d;
  logic                        timeout_q, timeout_d;
  logic [OVR_CNT_W-1:0]        ovr_q, ovr_d;
  logic [NUM_SOURCES-1:0]      en_q, en_d;
  logic [WD_W-1:0]             wd_q, wd_d;
  // Set by an aborted sequence: the following GAP restarts from the lowest enabled ID.
  logic                        restart_q, restart_d;

  logic                        done_sel;
  logic [SOURCE_SEL_ADDRW:0]   lo_pick, next_pick, rst_pick;

  // Returns {found, id} of the lowest set bit of mask at index >= start.
  function automatic logic [SOURCE_SEL_ADDRW:0] pick_from(
    input logic [NUM_SOURCES-1:0] mask,
    input int                     start
  );
    logic [SOURCE_SEL_ADDRW:0] r;
    r = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= start)) r = {1'b1, SOURCE_SEL_ADDRW'(i)};
    end
    return r;
  endfunction

  // Saturating increment: holds at the all-ones value.
  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Pick out the done bit of the source currently holding the bus.
  always_comb begin
    done_sel = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (sel_q == SOURCE_SEL_ADDRW'(i)) done_sel = src_done[i];
    end
  end

  assign lo_pick   = pick_from(src_enable, 0);
  assign next_pick = pick_from(en_q, int'(sel_q) + 1);
  assign rst_pick  = pick_from(en_q, 0);

  // Next-state and registered-output logic for the grant sequencer.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    awaited_d    = awaited_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    timeout_d    = timeout_q;
    ovr_d        = ovr_q;
    en_d         = en_q;
    wd_d         = wd_q;
    restart_d    = restart_q;

    if ((state_q != IDLE) && frame) begin
      // Abort: drop the bus for one cycle, then restart with the new mask.
      ovr_d     = sat_inc(ovr_q);
      en_d      = src_enable;
      state_d   = GAP;
      restart_d = 1'b1;
      awaited_d = 1'b0;
      busy_d    = 1'b1;
      wd_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame) begin
            en_d = src_enable;
            if (lo_pick[SOURCE_SEL_ADDRW]) begin
              state_d   = GRANT;
              sel_d     = lo_pick[SOURCE_SEL_ADDRW-1:0];
              awaited_d = 1'b1;
              busy_d    = 1'b1;
              wd_d      = '0;
            end else begin
              state_d      = DONE;
              frame_done_d = 1'b1;
              busy_d       = 1'b0;
            end
          end
        end
        GRANT: begin
          if (done_sel || (wd_q == WD_MAX)) begin
            state_d   = GAP;
            awaited_d = 1'b0;
            wd_d      = '0;
            if (!done_sel) timeout_d = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        GAP: begin
          restart_d = 1'b0;
          if (restart_q ? rst_pick[SOURCE_SEL_ADDRW] : next_pick[SOURCE_SEL_ADDRW]) begin
            state_d   = GRANT;
            sel_d     = restart_q ? rst_pick[SOURCE_SEL_ADDRW-1:0]
                                  : next_pick[SOURCE_SEL_ADDRW-1:0];
            awaited_d = 1'b1;
            busy_d    = 1'b1;
            wd_d      = '0;
          end else begin
            state_d      = DONE;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
          end
        end
        DONE: begin
          state_d   = IDLE;
          awaited_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end

    // Clearing the status wins over a same-cycle overrun or timeout.
    if (clear_status) begin
      timeout_d = 1'b0;
      ovr_d     = '0;
    end
  end

  // State and output registers; reset abandons any sequence in progress.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      awaited_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      ovr_q        <= '0;
      en_q         <= '0;
      wd_q         <= '0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      awaited_q    <= awaited_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      ovr_q        <= ovr_d;
      en_q         <= en_d;
      wd_q         <= wd_d;
      restart_q    <= restart_d;
    end
  end

  assign write_source_sel = sel_q;
  assign write_awaited    = awaited_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign timeout_flag     = timeout_q;
  assign overrun_count    = ovr_q;

endmodule
